// File: rtl/uart_reg_bank_if.sv
// Byte-stream handshake bundle between a UART core (master) and the register bank (slave).
interface uart_reg_bank_if;
    logic       rx_valid;
    logic [7:0] rx_data;
    logic       rx_ready;
    logic       rx_error;
    logic       tx_valid;
    logic [7:0] tx_data;
    logic       tx_ready;

    modport master (
        output rx_valid, rx_data, rx_error, tx_ready,
        input  rx_ready, tx_valid, tx_data
    );

    modport slave (
        input  rx_valid, rx_data, rx_error, tx_ready,
        output rx_ready, tx_valid, tx_data
    );
endinterface

// File: rtl/uart_reg_bank.sv
// UART byte-command decoder driving a bank of NumRegs x RegWidth registers with
// read-back, error responses, inter-byte timeout and a soft-reset command.
module uart_reg_bank #(
    parameter int NumRegs       = 4,
    parameter int RegWidth      = 8,
    parameter int TimeoutCycles = 1562500
) (
    input  logic                        i_clk,
    input  logic                        i_rst_n,
    uart_reg_bank_if.slave              bus,
    output logic [NumRegs*RegWidth-1:0] o_regs,
    output logic                        o_soft_reset,
    output logic                        o_timeout,
    output logic                        o_busy
);

    localparam int         NB            = RegWidth / 8;
    localparam int         TW            = $clog2(TimeoutCycles);
    localparam logic [7:0] AckByte       = 8'hA5;
    localparam logic [7:0] ErrByte       = 8'hEE;
    localparam logic [6:0] SoftResetAddr = 7'h7F;

    typedef enum logic [1:0] {IDLE, DATA, APPLY, RESP} state_t;

    state_t              state, next_state;
    logic [6:0]          cmd_addr;
    logic                cmd_write;
    logic [2:0]          byte_cnt;
    logic [2:0]          resp_cnt;
    logic [RegWidth-1:0] data_sr;
    logic [RegWidth-1:0] resp_sr;
    logic [RegWidth-1:0] read_val;
    logic [TW-1:0]       timer;
    logic [RegWidth-1:0] regs [NumRegs];
    logic                rx_ready_q;
    logic                tx_valid_q;

    logic rx_fire, tx_fire, data_accept, last_data, timeout_hit, last_resp;
    logic addr_valid, soft_cmd;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:  if (rx_fire) next_state = bus.rx_data[7] ? DATA : APPLY;
            DATA: begin
                if (bus.rx_error)       next_state = IDLE;
                else if (last_data)     next_state = APPLY;
                else if (timeout_hit)   next_state = IDLE;
            end
            APPLY: next_state = RESP;
            RESP:  if (last_resp) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // A framing error in DATA outranks a byte or a timeout arriving in the same cycle.
    always_comb begin
        rx_fire     = bus.rx_valid && rx_ready_q;
        tx_fire     = tx_valid_q && bus.tx_ready;
        data_accept = (state == DATA) && rx_fire && !bus.rx_error;
        last_data   = data_accept && (byte_cnt == 3'(NB - 1));
        timeout_hit = (state == DATA) && !bus.rx_error && !rx_fire
                      && (timer == TW'(TimeoutCycles - 1));
        last_resp   = (state == RESP) && tx_fire && (resp_cnt == 3'd1);
        addr_valid  = 32'(cmd_addr) < NumRegs;
        soft_cmd    = cmd_addr == SoftResetAddr;
        o_busy      = state != IDLE;
        read_val    = '0;
        for (int i = 0; i < NumRegs; i++) begin
            if (cmd_addr == 7'(i)) read_val = regs[i];
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            rx_ready_q   <= 1'b0;
            tx_valid_q   <= 1'b0;
            cmd_addr     <= '0;
            cmd_write    <= 1'b0;
            byte_cnt     <= '0;
            resp_cnt     <= '0;
            data_sr      <= '0;
            resp_sr      <= '0;
            timer        <= '0;
            o_soft_reset <= 1'b0;
            o_timeout    <= 1'b0;
            for (int i = 0; i < NumRegs; i++) regs[i] <= '0;
        end else begin
            rx_ready_q   <= (next_state == IDLE) || (next_state == DATA);
            o_soft_reset <= 1'b0;
            o_timeout    <= 1'b0;
            if (state != DATA) timer <= '0;
            case (state)
                IDLE: begin
                    if (rx_fire) begin
                        cmd_write <= bus.rx_data[7];
                        cmd_addr  <= bus.rx_data[6:0];
                        byte_cnt  <= '0;
                    end
                end
                DATA: begin
                    if (data_accept) begin
                        data_sr  <= (data_sr << 8) | RegWidth'(bus.rx_data);
                        byte_cnt <= byte_cnt + 3'd1;
                        timer    <= '0;
                    end else if (timeout_hit) begin
                        o_timeout <= 1'b1;
                        timer     <= '0;
                    end else if (!bus.rx_error) begin
                        timer <= timer + TW'(1);
                    end
                end
                APPLY: begin
                    tx_valid_q <= 1'b1;
                    resp_cnt   <= 3'd1;
                    resp_sr    <= RegWidth'(ErrByte) << (RegWidth - 8);
                    if (cmd_write) begin
                        if (addr_valid) begin
                            for (int i = 0; i < NumRegs; i++) begin
                                if (cmd_addr == 7'(i)) regs[i] <= data_sr;
                            end
                            resp_sr <= RegWidth'(AckByte) << (RegWidth - 8);
                        end else if (soft_cmd) begin
                            for (int i = 0; i < NumRegs; i++) regs[i] <= '0;
                            o_soft_reset <= 1'b1;
                            resp_sr      <= RegWidth'(AckByte) << (RegWidth - 8);
                        end
                    end else if (addr_valid) begin
                        resp_sr  <= read_val;
                        resp_cnt <= 3'(NB);
                    end
                end
                RESP: begin
                    if (tx_fire) begin
                        if (resp_cnt == 3'd1) begin
                            tx_valid_q <= 1'b0;
                            resp_sr    <= '0;
                        end else begin
                            resp_sr  <= resp_sr << 8;
                            resp_cnt <= resp_cnt - 3'd1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.rx_ready = rx_ready_q;
    assign bus.tx_valid = tx_valid_q;
    assign bus.tx_data  = resp_sr[RegWidth-1 -: 8];

    always_comb begin
        o_regs = '0;
        for (int i = 0; i < NumRegs; i++) o_regs[i*RegWidth +: RegWidth] = regs[i];
    end

endmodule

// File: tb/tb_uart_reg_bank.sv
// Directed bench for uart_reg_bank with 4 x 16-bit registers and a 16-cycle timeout.
module tb_uart_reg_bank;

    logic        clk;
    logic        rst_n;
    logic [63:0] regs;
    logic        soft_reset;
    logic        timeout;
    logic        busy;
    int          checks = 0;
    int          errors = 0;
    int          sr_count = 0;
    int          to_count = 0;
    int          base;

    uart_reg_bank_if bus ();

    uart_reg_bank #(
        .NumRegs       (4),
        .RegWidth      (16),
        .TimeoutCycles (16)
    ) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .bus          (bus),
        .o_regs       (regs),
        .o_soft_reset (soft_reset),
        .o_timeout    (timeout),
        .o_busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (soft_reset) sr_count++;
        if (timeout)    to_count++;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired before the end of the sequence");
        $fatal(1, "[TB] watchdog");
    end

    task automatic check_output(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Holds a byte on rx until the bank takes it; returns at the negedge after the transfer.
    task automatic apply_stimulus(input logic [7:0] b);
        int n = 0;
        @(negedge clk);
        bus.rx_valid = 1'b1;
        bus.rx_data  = b;
        while (!bus.rx_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        check_output("rx_accept", 64'(n < 50), 64'd1);
        @(negedge clk);
        bus.rx_valid = 1'b0;
    endtask

    task automatic expect_byte(input string tag, input logic [7:0] exp);
        int n = 0;
        while (!bus.tx_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        check_output({tag, "_valid"}, 64'(bus.tx_valid), 64'd1);
        check_output(tag, 64'(bus.tx_data), 64'(exp));
        @(negedge clk);
    endtask

    task automatic write_reg(input string tag, input logic [7:0] cmd, input logic [7:0] hi,
                             input logic [7:0] lo, input logic [7:0] exp_resp);
        apply_stimulus(cmd);
        apply_stimulus(hi);
        apply_stimulus(lo);
        check_output({tag, "_apply_valid"}, 64'(bus.tx_valid), 64'd0);
        @(negedge clk);
        check_output({tag, "_resp_valid"}, 64'(bus.tx_valid), 64'd1);
        check_output({tag, "_resp"}, 64'(bus.tx_data), 64'(exp_resp));
        @(negedge clk);
        check_output({tag, "_done_valid"}, 64'(bus.tx_valid), 64'd0);
    endtask

    task automatic read_reg(input string tag, input logic [7:0] cmd, input int nbytes,
                            input logic [15:0] exp);
        apply_stimulus(cmd);
        check_output({tag, "_apply_valid"}, 64'(bus.tx_valid), 64'd0);
        @(negedge clk);
        if (nbytes == 2) begin
            expect_byte({tag, "_hi"}, exp[15:8]);
            expect_byte({tag, "_lo"}, exp[7:0]);
        end else begin
            expect_byte({tag, "_byte"}, exp[7:0]);
        end
        check_output({tag, "_done_valid"}, 64'(bus.tx_valid), 64'd0);
    endtask

    initial begin
        rst_n        = 1'b0;
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'h00;
        bus.rx_error = 1'b0;
        bus.tx_ready = 1'b1;
        repeat (3) @(negedge clk);
        check_output("rst_rx_ready", 64'(bus.rx_ready), 64'd0);
        check_output("rst_tx_valid", 64'(bus.tx_valid), 64'd0);
        check_output("rst_tx_data", 64'(bus.tx_data), 64'd0);
        check_output("rst_regs", regs, 64'd0);
        check_output("rst_busy", 64'(busy), 64'd0);
        rst_n = 1'b1;
        #1;
        check_output("rel_rx_ready_low", 64'(bus.rx_ready), 64'd0);
        @(negedge clk);
        check_output("rel_rx_ready_high", 64'(bus.rx_ready), 64'd1);

        $display("[TB] write then read register 2");
        write_reg("wr2", 8'h82, 8'h12, 8'h3C, 8'hA5);
        check_output("wr2_regs", regs, 64'h0000_123C_0000_0000);
        read_reg("rd2", 8'h02, 2, 16'h123C);

        $display("[TB] write then read register 1");
        write_reg("wr1", 8'h81, 8'hBE, 8'hEF, 8'hA5);
        check_output("wr1_regs", regs, 64'h0000_123C_BEEF_0000);
        read_reg("rd1", 8'h01, 2, 16'hBEEF);

        $display("[TB] out-of-range accesses");
        read_reg("rd5", 8'h05, 1, 16'h00EE);
        write_reg("wr5", 8'h85, 8'h11, 8'h22, 8'hEE);
        check_output("wr5_regs", regs, 64'h0000_123C_BEEF_0000);
        read_reg("rd7f", 8'h7F, 1, 16'h00EE);

        $display("[TB] inter-byte timeout");
        base = to_count;
        apply_stimulus(8'h81);
        repeat (10) @(negedge clk);
        check_output("to_busy_early", 64'(busy), 64'd1);
        check_output("to_none_early", 64'(to_count - base), 64'd0);
        repeat (10) @(negedge clk);
        check_output("to_busy_after", 64'(busy), 64'd0);
        check_output("to_pulses", 64'(to_count - base), 64'd1);
        check_output("to_regs", regs, 64'h0000_123C_BEEF_0000);
        read_reg("to_rd1", 8'h01, 2, 16'hBEEF);

        $display("[TB] tx backpressure");
        bus.tx_ready = 1'b0;
        apply_stimulus(8'h02);
        @(negedge clk);
        for (int i = 0; i < 10; i++) begin
            check_output("bp_valid", 64'(bus.tx_valid), 64'd1);
            check_output("bp_data", 64'(bus.tx_data), 64'h12);
            check_output("bp_rx_ready", 64'(bus.rx_ready), 64'd0);
            @(negedge clk);
        end
        bus.tx_ready = 1'b1;
        expect_byte("bp_hi", 8'h12);
        expect_byte("bp_lo", 8'h3C);
        check_output("bp_done_valid", 64'(bus.tx_valid), 64'd0);

        $display("[TB] rx error during data phase");
        apply_stimulus(8'h83);
        apply_stimulus(8'h77);
        @(negedge clk);
        bus.rx_valid = 1'b1;
        bus.rx_data  = 8'h99;
        bus.rx_error = 1'b1;
        @(negedge clk);
        bus.rx_valid = 1'b0;
        bus.rx_error = 1'b0;
        check_output("err_busy", 64'(busy), 64'd0);
        repeat (4) @(negedge clk);
        check_output("err_no_resp", 64'(bus.tx_valid), 64'd0);
        check_output("err_regs", regs, 64'h0000_123C_BEEF_0000);
        read_reg("err_rd3", 8'h03, 2, 16'h0000);

        $display("[TB] soft reset command");
        base = sr_count;
        write_reg("soft", 8'hFF, 8'h00, 8'h00, 8'hA5);
        check_output("soft_regs", regs, 64'd0);
        check_output("soft_pulses", 64'(sr_count - base), 64'd1);

        $display("[TB] reset during data phase");
        write_reg("wr0", 8'h80, 8'h12, 8'h34, 8'hA5);
        check_output("wr0_regs", regs, 64'h0000_0000_0000_1234);
        apply_stimulus(8'h81);
        apply_stimulus(8'hAA);
        rst_n = 1'b0;
        #1;
        check_output("rstd_busy", 64'(busy), 64'd0);
        check_output("rstd_rx_ready", 64'(bus.rx_ready), 64'd0);
        check_output("rstd_regs", regs, 64'd0);
        check_output("rstd_tx_valid", 64'(bus.tx_valid), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        $display("[TB] reset during response");
        write_reg("wr0b", 8'h80, 8'h55, 8'h66, 8'hA5);
        bus.tx_ready = 1'b0;
        apply_stimulus(8'h00);
        @(negedge clk);
        check_output("rstr_pre_data", 64'(bus.tx_data), 64'h55);
        rst_n = 1'b0;
        #1;
        check_output("rstr_tx_valid", 64'(bus.tx_valid), 64'd0);
        check_output("rstr_tx_data", 64'(bus.tx_data), 64'd0);
        check_output("rstr_regs", regs, 64'd0);
        check_output("rstr_busy", 64'(busy), 64'd0);
        check_output("rstr_rx_ready", 64'(bus.rx_ready), 64'd0);
        @(negedge clk);
        rst_n        = 1'b1;
        bus.tx_ready = 1'b1;
        read_reg("post_rst_rd0", 8'h00, 2, 16'h0000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
